// File: rtl/edge_histogram_line_tracker.sv
// Edge histogram line tracker.
// Takes a YUYV camera byte stream and uses every Y byte (full horizontal
// resolution). Horizontal luma edges are counted into NUM_BINS column bins.
// On each vsync rise the bins are scanned, the strongest column is published
// with its count, and the bins are cleared for the next frame.
// Optional build macro: ROW_WINDOW_EN adds row_first/row_last ports so that
// only a band of rows contributes to the histogram.

module edge_histogram_line_tracker #(
    parameter int unsigned NUM_BINS  = 16,
    parameter int unsigned BIN_WIDTH = 40,
    parameter int unsigned TAP       = 6,
    parameter int unsigned COUNT_W   = 16,
    parameter int unsigned PIX_W     = 11,
    localparam int unsigned BIN_W    = $clog2(NUM_BINS)
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic [7:0]         camera_data,
    input  logic               href,
    input  logic               vsync,
    input  logic [7:0]         threshold,
    input  logic [COUNT_W-1:0] min_count,
`ifdef ROW_WINDOW_EN
    input  logic [9:0]         row_first,
    input  logic [9:0]         row_last,
`endif
    output logic [BIN_W-1:0]   line_position,
    output logic [COUNT_W-1:0] max_count,
    output logic               line_found,
    output logic               result_valid,
    output logic               busy
);

    typedef enum logic [1:0] {StAccum, StScan, StPublish, StClear} state_e;
    typedef enum logic [1:0] {PhY1, PhU, PhY2, PhV} phase_e;

    localparam logic [PIX_W-1:0]   PIX_MAX  = {PIX_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [BIN_W-1:0]   LAST_BIN = BIN_W'(NUM_BINS - 1);

    state_e              state_q, state_d;
    phase_e              phase_q;
    logic [PIX_W-1:0]    pix_idx_q;
    // Previous TAP luma samples; together with the incoming byte they form
    // the (TAP+1)-sample window, so the edge test needs no extra pipeline stage.
    logic [7:0]          y_q [TAP];
    logic [COUNT_W-1:0]  bins_q [NUM_BINS];
    logic                vsync_q;

    logic [BIN_W-1:0]    scan_idx_q, scan_idx_d;
    logic [BIN_W-1:0]    cand_idx_q, cand_idx_d;
    logic [COUNT_W-1:0]  cand_cnt_q, cand_cnt_d;

    logic [BIN_W-1:0]    line_position_d;
    logic [COUNT_W-1:0]  max_count_d;
    logic                line_found_d;
    logic                result_valid_d;

    logic                y_byte;
    logic                vsync_rise;
    logic                tap_ok;
    logic                is_edge;
    logic                row_ok;
    logic                bin_inc;
    logic [BIN_W-1:0]    bin_sel;
    logic signed [8:0]   delta;
    logic signed [8:0]   thr_pos;
    logic signed [8:0]   thr_neg;
    logic [31:0]         quot;

    assign y_byte     = href && ((phase_q == PhY1) || (phase_q == PhY2));
    assign vsync_rise = vsync && !vsync_q;
    assign busy       = (state_q != StAccum);

    // Byte phase tracking; href low realigns to the first Y byte.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            phase_q <= PhY1;
        end else if (!href) begin
            phase_q <= PhY1;
        end else begin
            unique case (phase_q)
                PhY1:    phase_q <= PhU;
                PhU:     phase_q <= PhY2;
                PhY2:    phase_q <= PhV;
                default: phase_q <= PhY1;
            endcase
        end
    end

    // Pixel index within the line, saturating.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            pix_idx_q <= '0;
        end else if (!href) begin
            pix_idx_q <= '0;
        end else if (y_byte && (pix_idx_q != PIX_MAX)) begin
            pix_idx_q <= pix_idx_q + 1'b1;
        end
    end

    // Luma shift register, advanced on every Y byte.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(TAP); i++) begin
                y_q[i] <= '0;
            end
        end else if (y_byte) begin
            y_q[0] <= camera_data;
            for (int i = 1; i < int'(TAP); i++) begin
                y_q[i] <= y_q[i-1];
            end
        end
    end

    // Edge detection on newest minus oldest sample, strict threshold compare.
    always_comb begin
        delta   = $signed({1'b0, camera_data}) - $signed({1'b0, y_q[TAP-1]});
        thr_pos = $signed({1'b0, threshold});
        thr_neg = -thr_pos;
        is_edge = (delta > thr_pos) || (delta < thr_neg);
        tap_ok  = (pix_idx_q >= PIX_W'(TAP));
    end

    // Column bin select; pixels past the last full bin fold into the last bin.
    always_comb begin
        quot = 32'(pix_idx_q) / BIN_WIDTH;
        if (quot >= NUM_BINS) begin
            bin_sel = LAST_BIN;
        end else begin
            bin_sel = BIN_W'(quot);
        end
    end

    // Previous vsync for rise detection.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

`ifdef ROW_WINDOW_EN
    logic       href_q;
    logic [9:0] row_q;

    // Row counter: cleared at frame start, advanced at the end of each line.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            href_q <= 1'b0;
            row_q  <= '0;
        end else begin
            href_q <= href;
            if (vsync_rise) begin
                row_q <= '0;
            end else if (href_q && !href && (row_q != 10'h3ff)) begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    assign row_ok = (row_q >= row_first) && (row_q <= row_last);
`else
    assign row_ok = 1'b1;
`endif

    assign bin_inc = (state_q == StAccum) && y_byte && tap_ok && is_edge && row_ok;

    // Histogram bins: saturating increment while accumulating, bulk clear after publish.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                bins_q[i] <= '0;
            end
        end else if (state_q == StClear) begin
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                bins_q[i] <= '0;
            end
        end else if (bin_inc && (bins_q[bin_sel] != CNT_MAX)) begin
            bins_q[bin_sel] <= bins_q[bin_sel] + 1'b1;
        end
    end

    // FSM and scan datapath registers.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state_q       <= StAccum;
            scan_idx_q    <= '0;
            cand_idx_q    <= '0;
            cand_cnt_q    <= '0;
            line_position <= '0;
            max_count     <= '0;
            line_found    <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            cand_idx_q    <= cand_idx_d;
            cand_cnt_q    <= cand_cnt_d;
            line_position <= line_position_d;
            max_count     <= max_count_d;
            line_found    <= line_found_d;
            result_valid  <= result_valid_d;
        end
    end

    // Next state, argmax scan (ties keep the lowest index) and publish.
    always_comb begin
        state_d         = state_q;
        scan_idx_d      = scan_idx_q;
        cand_idx_d      = cand_idx_q;
        cand_cnt_d      = cand_cnt_q;
        line_position_d = line_position;
        max_count_d     = max_count;
        line_found_d    = line_found;
        result_valid_d  = 1'b0;
        unique case (state_q)
            StAccum: begin
                if (vsync_rise) begin
                    state_d    = StScan;
                    scan_idx_d = '0;
                end
            end
            StScan: begin
                if ((scan_idx_q == '0) || (bins_q[scan_idx_q] > cand_cnt_q)) begin
                    cand_idx_d = scan_idx_q;
                    cand_cnt_d = bins_q[scan_idx_q];
                end
                if (scan_idx_q == LAST_BIN) begin
                    state_d = StPublish;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            StPublish: begin
                line_position_d = cand_idx_q;
                max_count_d     = cand_cnt_q;
                line_found_d    = (cand_cnt_q >= min_count);
                result_valid_d  = 1'b1;
                state_d         = StClear;
            end
            StClear: begin
                state_d = StAccum;
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

endmodule

// File: tb/tb_edge_histogram_line_tracker.sv
// Directed bench for edge_histogram_line_tracker. A second instance with a
// 4-bit counter shares all stimulus to exercise count saturation.
`timescale 1ns/1ps

module tb_edge_histogram_line_tracker;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic [7:0]  camera_data;
    logic        href;
    logic        vsync;
    logic [7:0]  threshold;
    logic [15:0] min_count;
    logic [3:0]  min_count_sat;
    logic [9:0]  row_first;
    logic [9:0]  row_last;

    logic [3:0]  line_position;
    logic [15:0] max_count;
    logic        line_found;
    logic        result_valid;
    logic        busy;

    logic [3:0]  sat_position;
    logic [3:0]  sat_count;
    logic        sat_found;
    logic        sat_valid;
    logic        sat_busy;

    logic [7:0]  line_y [1024];
    int          checks = 0;
    int          errors = 0;

    int          rv_cycle;
    int          rv_count;
    logic        busy1;
    logic        busy19;

    always #5 pixel_clock = ~pixel_clock;

    edge_histogram_line_tracker dut (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .camera_data  (camera_data),
        .href         (href),
        .vsync        (vsync),
        .threshold    (threshold),
        .min_count    (min_count),
`ifdef ROW_WINDOW_EN
        .row_first    (row_first),
        .row_last     (row_last),
`endif
        .line_position(line_position),
        .max_count    (max_count),
        .line_found   (line_found),
        .result_valid (result_valid),
        .busy         (busy)
    );

    edge_histogram_line_tracker #(.COUNT_W(4)) dut_sat (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .camera_data  (camera_data),
        .href         (href),
        .vsync        (vsync),
        .threshold    (threshold),
        .min_count    (min_count_sat),
`ifdef ROW_WINDOW_EN
        .row_first    (row_first),
        .row_last     (row_last),
`endif
        .line_position(sat_position),
        .max_count    (sat_count),
        .line_found   (sat_found),
        .result_valid (sat_valid),
        .busy         (sat_busy)
    );

    task automatic drive_byte(input logic [7:0] b);
        @(negedge pixel_clock);
        href        = 1'b1;
        camera_data = b;
    endtask

    // One YUYV line of npix pixels from line_y, followed by horizontal blanking.
    task automatic send_line(input int npix);
        for (int p = 0; p < npix; p += 2) begin
            drive_byte(line_y[p]);
            drive_byte(8'd128);
            drive_byte(line_y[p+1]);
            drive_byte(8'd128);
        end
        @(negedge pixel_clock);
        href        = 1'b0;
        camera_data = 8'd0;
        repeat (3) @(posedge pixel_clock);
    endtask

    task automatic fill_step(input logic [7:0] lo, input logic [7:0] hi, input int pos);
        for (int i = 0; i < 1024; i++) begin
            line_y[i] = (i < pos) ? lo : hi;
        end
    endtask

    // Raise vsync, then watch 24 cycles after the sampling edge.
    task automatic run_frame(input bit retrig);
        @(negedge pixel_clock);
        vsync = 1'b1;
        @(posedge pixel_clock);
        rv_cycle = 0;
        rv_count = 0;
        busy1    = 1'b0;
        busy19   = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge pixel_clock);
            #1;
            if (result_valid) begin
                rv_count++;
                if (rv_cycle == 0) rv_cycle = c;
            end
            if (c == 1) busy1 = busy;
            if (c == 19) busy19 = busy;
            if (retrig && c == 3) vsync = 1'b0;
            if (retrig && c == 6) vsync = 1'b1;
        end
        @(negedge pixel_clock);
        vsync = 1'b0;
        repeat (2) @(posedge pixel_clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge pixel_clock);
        #1;
        checks++;
        if (line_position !== 4'd0) begin
            errors++; $display("FAIL reset_pos: got %0d expected 0", line_position);
        end
        checks++;
        if (max_count !== 16'd0) begin
            errors++; $display("FAIL reset_max: got %0d expected 0", max_count);
        end
        checks++;
        if (line_found !== 1'b0) begin
            errors++; $display("FAIL reset_found: got %0b expected 0", line_found);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", result_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b expected 0", busy);
        end
        @(negedge pixel_clock);
        reset = 1'b0;
        repeat (2) @(posedge pixel_clock);
    endtask

    task automatic test_single_edge();
        threshold = 8'd10;
        min_count = 16'd1;
        fill_step(8'd20, 8'd200, 100);
        send_line(160);
        run_frame(1'b0);
        checks++;
        if (line_position !== 4'd2) begin
            errors++; $display("FAIL single_pos: got %0d expected 2", line_position);
        end
        checks++;
        if (max_count !== 16'd6) begin
            errors++; $display("FAIL single_max: got %0d expected 6", max_count);
        end
        checks++;
        if (line_found !== 1'b1) begin
            errors++; $display("FAIL single_found: got %0b expected 1", line_found);
        end
        checks++;
        if (rv_cycle !== 17) begin
            errors++; $display("FAIL single_latency: got %0d expected 17", rv_cycle);
        end
        checks++;
        if (rv_count !== 1) begin
            errors++; $display("FAIL single_pulses: got %0d expected 1", rv_count);
        end
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL single_busy_scan: got %0b expected 1", busy1);
        end
        checks++;
        if (busy19 !== 1'b0) begin
            errors++; $display("FAIL single_busy_done: got %0b expected 0", busy19);
        end
    endtask

    task automatic test_reset_mid_scan();
        fill_step(8'd20, 8'd200, 100);
        send_line(160);
        @(negedge pixel_clock);
        vsync = 1'b1;
        @(posedge pixel_clock);
        repeat (5) @(posedge pixel_clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (line_position !== 4'd0 || max_count !== 16'd0 || line_found !== 1'b0) begin
            errors++;
            $display("FAIL midscan_outputs: got pos=%0d max=%0d found=%0b expected 0/0/0",
                     line_position, max_count, line_found);
        end
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL midscan_busy: got busy=%0b valid=%0b expected 0/0", busy, result_valid);
        end
        @(negedge pixel_clock);
        reset = 1'b0;
        vsync = 1'b0;
        repeat (2) @(posedge pixel_clock);
        min_count = 16'd1;
        run_frame(1'b0);
        checks++;
        if (line_position !== 4'd0 || max_count !== 16'd0 || line_found !== 1'b0) begin
            errors++;
            $display("FAIL midscan_next: got pos=%0d max=%0d found=%0b expected 0/0/0",
                     line_position, max_count, line_found);
        end
        checks++;
        if (rv_count !== 1) begin
            errors++; $display("FAIL midscan_pulses: got %0d expected 1", rv_count);
        end
    endtask

    task automatic test_threshold_equal();
        fill_step(8'd20, 8'd30, 100);
        threshold = 8'd10;
        send_line(160);
        run_frame(1'b0);
        checks++;
        if (max_count !== 16'd0 || line_found !== 1'b0 || line_position !== 4'd0) begin
            errors++;
            $display("FAIL thr_equal: got pos=%0d max=%0d found=%0b expected 0/0/0",
                     line_position, max_count, line_found);
        end
        threshold = 8'd9;
        send_line(160);
        run_frame(1'b0);
        checks++;
        if (max_count !== 16'd6 || line_position !== 4'd2) begin
            errors++;
            $display("FAIL thr_below: got pos=%0d max=%0d expected 2/6", line_position, max_count);
        end
        threshold = 8'd10;
    endtask

    task automatic test_tie();
        for (int i = 0; i < 1024; i++) begin
            line_y[i] = (i >= 130 && i < 370) ? 8'd150 : 8'd50;
        end
        min_count = 16'd6;
        send_line(400);
        run_frame(1'b0);
        checks++;
        if (line_position !== 4'd3) begin
            errors++; $display("FAIL tie_pos: got %0d expected 3", line_position);
        end
        checks++;
        if (max_count !== 16'd6 || line_found !== 1'b1) begin
            errors++;
            $display("FAIL tie_found_eq: got max=%0d found=%0b expected 6/1", max_count, line_found);
        end
        min_count = 16'd7;
        send_line(400);
        run_frame(1'b0);
        checks++;
        if (line_found !== 1'b0 || line_position !== 4'd3) begin
            errors++;
            $display("FAIL tie_found_above: got pos=%0d found=%0b expected 3/0",
                     line_position, line_found);
        end
        min_count = 16'd1;
    endtask

    task automatic test_clamp_last_bin();
        fill_step(8'd20, 8'd200, 680);
        send_line(700);
        run_frame(1'b0);
        checks++;
        if (line_position !== 4'd15 || max_count !== 16'd6) begin
            errors++;
            $display("FAIL clamp: got pos=%0d max=%0d expected 15/6", line_position, max_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 1024; i++) begin
            line_y[i] = (((i / 6) % 2) == 1) ? 8'd200 : 8'd20;
        end
        min_count_sat = 4'd1;
        send_line(40);
        run_frame(1'b0);
        checks++;
        if (max_count !== 16'd34 || line_position !== 4'd0) begin
            errors++;
            $display("FAIL sat_wide: got pos=%0d max=%0d expected 0/34", line_position, max_count);
        end
        checks++;
        if (sat_count !== 4'd15 || sat_position !== 4'd0 || sat_found !== 1'b1) begin
            errors++;
            $display("FAIL sat_narrow: got pos=%0d max=%0d found=%0b expected 0/15/1",
                     sat_position, sat_count, sat_found);
        end
    endtask

    task automatic test_back_to_back();
        fill_step(8'd20, 8'd200, 100);
        send_line(160);
        run_frame(1'b1);
        checks++;
        if (rv_count !== 1) begin
            errors++; $display("FAIL b2b_retrigger: got %0d pulses expected 1", rv_count);
        end
        checks++;
        if (max_count !== 16'd6 || line_position !== 4'd2) begin
            errors++;
            $display("FAIL b2b_first: got pos=%0d max=%0d expected 2/6", line_position, max_count);
        end
        run_frame(1'b0);
        checks++;
        if (max_count !== 16'd0 || line_found !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cleared: got max=%0d found=%0b expected 0/0", max_count, line_found);
        end
    endtask

`ifdef ROW_WINDOW_EN
    task automatic test_row_window();
        run_frame(1'b0);
        row_first = 10'd2;
        row_last  = 10'd3;
        fill_step(8'd20, 8'd200, 100);
        for (int r = 0; r < 6; r++) begin
            send_line(160);
        end
        run_frame(1'b1);
        checks++;
        if (max_count !== 16'd12 || line_position !== 4'd2) begin
            errors++;
            $display("FAIL row_window: got pos=%0d max=%0d expected 2/12", line_position, max_count);
        end
        checks++;
        if (rv_count !== 1) begin
            errors++; $display("FAIL row_retrigger: got %0d pulses expected 1", rv_count);
        end
        row_first = 10'd0;
        row_last  = 10'd1023;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        camera_data   = 8'd0;
        href          = 1'b0;
        vsync         = 1'b0;
        threshold     = 8'd10;
        min_count     = 16'd1;
        min_count_sat = 4'd1;
        row_first     = 10'd0;
        row_last      = 10'd1023;

        test_reset();
        test_single_edge();
        test_reset_mid_scan();
        test_threshold_equal();
        test_tie();
        test_clamp_last_bin();
        test_saturation();
        test_back_to_back();
`ifdef ROW_WINDOW_EN
        test_row_window();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
